// File: rtl/dma_sched_pkg.sv
// Shared types and helpers for the multi-requester DMA read scheduler.
package dma_sched_pkg;

    // Scheduler states: pick a requester, offer a chunk, wait for its last beat, report completion
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One read descriptor as seen by the scheduler
    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
    } desc_t;

    // Bytes to issue next: the remainder, capped at the chunk limit
    function automatic logic [31:0] chunk_len(input logic [31:0] rem,
                                              input logic [31:0] max_chunk);
        return (rem > max_chunk) ? max_chunk : rem;
    endfunction

endpackage

// File: rtl/dma_rr_arb.sv
// Round-robin arbiter: searches upward from pointer+1 (wrapping) for the
// first active request and returns it both one-hot and as an index.
module dma_rr_arb #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   pointer,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   index
);

    logic          found;
    logic [IW-1:0] cand;

    // Walk the requesters starting just past the last grant; the first hit wins
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(pointer) + i) % NREQ);
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/dma_r_sched.sv
// Scheduler in front of the single-channel DMA read engine: accepts
// descriptors from several requesters round-robin, slices each into chunks
// of at most MAX_CHUNK bytes and issues them to the engine one at a time.
module dma_r_sched
    import dma_sched_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int AXI_DW    = 128,
    parameter int MAX_CHUNK = 4096
) (
    input  logic                        usr_clk,
    input  logic                        usr_reset_n,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][31:0]       req_src_sa,
    input  logic [NREQ-1:0][31:0]       req_dst_sa,
    input  logic [NREQ-1:0][31:0]       req_len,
    output logic [NREQ-1:0]             req_done,
    output logic                        cfg_valid,
    input  logic                        cfg_ready,
    output logic [31:0]                 cfg_src_sa,
    output logic [31:0]                 cfg_dst_sa,
    output logic [31:0]                 cfg_len,
    input  logic                        xfer_done,
    output logic                        busy,
    output logic [$clog2(NREQ)-1:0]     cur_id
);

    localparam int          IW          = $clog2(NREQ);
    localparam logic [31:0] MAX_CHUNK_W = 32'(MAX_CHUNK);

    // A chunk limit below one beat or not a power of two would break the engine's burst math
    if (MAX_CHUNK < AXI_DW / 8 || (MAX_CHUNK & (MAX_CHUNK - 1)) != 0) begin : g_bad_max_chunk
        $error("dma_r_sched: MAX_CHUNK must be a power of two and at least one beat");
    end

    state_t          state;
    desc_t           rem;
    desc_t           req_desc;
    logic [IW-1:0]   pointer;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            arb_en;
    logic [31:0]     chunk;
    logic [31:0]     next_len;

    // Grants are only offered while idle and never while reset holds the block down
    assign arb_en    = (state == ST_IDLE) && usr_reset_n;
    assign req_ready = grant;

    dma_rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req     (req_valid),
        .pointer (pointer),
        .enable  (arb_en),
        .grant   (grant),
        .index   (grant_idx)
    );

    // Select the granted descriptor and work out the size of the chunk in flight
    always_comb begin
        req_desc.src = req_src_sa[grant_idx];
        req_desc.dst = req_dst_sa[grant_idx];
        req_desc.len = req_len[grant_idx];
        chunk        = chunk_len(rem.len, MAX_CHUNK_W);
        next_len     = rem.len - chunk;
    end

    // Main scheduler FSM with all engine-facing and status outputs registered
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            state      <= ST_IDLE;
            rem        <= '0;
            pointer    <= '0;
            cur_id     <= '0;
            busy       <= 1'b0;
            req_done   <= '0;
            cfg_valid  <= 1'b0;
            cfg_src_sa <= '0;
            cfg_dst_sa <= '0;
            cfg_len    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        rem     <= req_desc;
                        cur_id  <= grant_idx;
                        pointer <= grant_idx;
                        busy    <= 1'b1;
                        if (req_desc.len == 32'd0) begin
                            state    <= ST_DONE;
                            req_done <= grant;
                        end else begin
                            state      <= ST_ISSUE;
                            cfg_valid  <= 1'b1;
                            cfg_src_sa <= req_desc.src;
                            cfg_dst_sa <= req_desc.dst;
                            cfg_len    <= chunk_len(req_desc.len, MAX_CHUNK_W);
                        end
                    end
                end
                ST_ISSUE: begin
                    if (cfg_ready) begin
                        cfg_valid <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (xfer_done) begin
                        rem.src <= rem.src + chunk;
                        rem.dst <= rem.dst + chunk;
                        rem.len <= next_len;
                        if (next_len == 32'd0) begin
                            state    <= ST_DONE;
                            req_done <= {{(NREQ-1){1'b0}}, 1'b1} << cur_id;
                        end else begin
                            state      <= ST_ISSUE;
                            cfg_valid  <= 1'b1;
                            cfg_src_sa <= rem.src + chunk;
                            cfg_dst_sa <= rem.dst + chunk;
                            cfg_len    <= chunk_len(next_len, MAX_CHUNK_W);
                        end
                    end
                end
                ST_DONE: begin
                    req_done <= '0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_r_sched.sv
// Bench for dma_r_sched: table of single-descriptor jobs plus hand-written
// sequences for reset, round-robin order, engine back-pressure and abort.
module tb_dma_r_sched;

    localparam int NREQ = 4;
    localparam int MAXC = 4096;

    logic                  usr_clk = 1'b0;
    logic                  usr_reset_n = 1'b0;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][31:0] req_src_sa;
    logic [NREQ-1:0][31:0] req_dst_sa;
    logic [NREQ-1:0][31:0] req_len;
    logic [NREQ-1:0]       req_done;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [31:0]           cfg_src_sa;
    logic [31:0]           cfg_dst_sa;
    logic [31:0]           cfg_len;
    logic                  xfer_done;
    logic                  busy;
    logic [1:0]            cur_id;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        int          id;
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
        int          chunks;
        logic [31:0] last_len;
    } vec_t;

    vec_t vecs[6];

    dma_r_sched #(
        .NREQ      (NREQ),
        .AXI_DW    (128),
        .MAX_CHUNK (MAXC)
    ) dut (
        .usr_clk     (usr_clk),
        .usr_reset_n (usr_reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_src_sa  (req_src_sa),
        .req_dst_sa  (req_dst_sa),
        .req_len     (req_len),
        .req_done    (req_done),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_src_sa  (cfg_src_sa),
        .cfg_dst_sa  (cfg_dst_sa),
        .cfg_len     (cfg_len),
        .xfer_done   (xfer_done),
        .busy        (busy),
        .cur_id      (cur_id)
    );

    // Free-running clock
    always #5 usr_clk = ~usr_clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [31:0] src,
                                 input logic [31:0] dst, input logic [31:0] len);
        req_src_sa[id] = src;
        req_dst_sa[id] = dst;
        req_len[id]    = len;
        req_valid[id]  = 1'b1;
    endtask

    // Starts on the falling edge right after the grant; serves every chunk and ends back in IDLE
    task automatic driveChunks(input int id, input logic [31:0] src, input logic [31:0] dst,
                               input int chunks, input logic [31:0] last_len);
        logic [31:0] oh;
        logic [31:0] off;
        oh = 32'(1) << id;
        if (chunks == 0) begin
            checkOutput("done_len0", 32'(req_done), oh);
            checkOutput("no_cfg_len0", 32'(cfg_valid), 32'd0);
        end
        for (int k = 0; k < chunks; k++) begin
            off = 32'(k) * 32'(MAXC);
            checkOutput("cfg_valid", 32'(cfg_valid), 32'd1);
            checkOutput("cfg_src", cfg_src_sa, src + off);
            checkOutput("cfg_dst", cfg_dst_sa, dst + off);
            checkOutput("cfg_len", cfg_len, (k == chunks - 1) ? last_len : 32'(MAXC));
            checkOutput("busy", 32'(busy), 32'd1);
            cfg_ready = 1'b1;
            @(negedge usr_clk);
            cfg_ready = 1'b0;
            checkOutput("cfg_drop", 32'(cfg_valid), 32'd0);
            @(negedge usr_clk);
            xfer_done = 1'b1;
            @(negedge usr_clk);
            xfer_done = 1'b0;
            checkOutput("req_done", 32'(req_done), (k == chunks - 1) ? oh : 32'd0);
        end
        @(negedge usr_clk);
        checkOutput("done_clear", 32'(req_done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
    endtask

    // Single requester job from IDLE: handshake, then all of its chunks
    task automatic runJob(input vec_t v);
        applyStimulus(v.id, v.src, v.dst, v.len);
        #1;
        checkOutput("req_ready", 32'(req_ready), 32'(1) << v.id);
        @(negedge usr_clk);
        req_valid[v.id] = 1'b0;
        checkOutput("cur_id", 32'(cur_id), 32'(v.id));
        driveChunks(v.id, v.src, v.dst, v.chunks, v.last_len);
    endtask

    initial begin
        int ord[4];
        int g;
        vecs[0] = '{0, 32'h8000_0000, 32'h0000_0100, 32'h40,  1, 32'h40};
        vecs[1] = '{2, 32'h1000_0000, 32'h0000_0000, 32'd10000, 3, 32'd1808};
        vecs[2] = '{3, 32'h1234_0000, 32'h0000_4000, 32'd0,   0, 32'd0};
        vecs[3] = '{1, 32'hFFFF_F000, 32'h0000_2000, 32'd8197, 3, 32'd5};
        vecs[4] = '{2, 32'h0000_8000, 32'h0001_0000, 32'd4096, 1, 32'd4096};
        vecs[5] = '{0, 32'h0000_0010, 32'h0000_0020, 32'd4097, 2, 32'd1};
        ord = '{1, 2, 3, 0};

        req_valid  = '0;
        req_src_sa = '0;
        req_dst_sa = '0;
        req_len    = '0;
        cfg_ready  = 1'b0;
        xfer_done  = 1'b0;

        // Reset state
        repeat (2) @(negedge usr_clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_cfg_valid", 32'(cfg_valid), 32'd0);
        checkOutput("rst_cfg_src", cfg_src_sa, 32'd0);
        checkOutput("rst_cfg_dst", cfg_dst_sa, 32'd0);
        checkOutput("rst_cfg_len", cfg_len, 32'd0);
        checkOutput("rst_req_done", 32'(req_done), 32'd0);
        checkOutput("rst_cur_id", 32'(cur_id), 32'd0);

        // All requesters valid out of reset: grants rotate 1,2,3,0
        for (int i = 0; i < NREQ; i++)
            applyStimulus(i, 32'h4000_0000 + 32'(i) * 32'h100, 32'(i) * 32'h1000, 32'd64);
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge usr_clk);
        usr_reset_n = 1'b1;
        for (int o = 0; o < NREQ; o++) begin
            g = ord[o];
            #1;
            checkOutput("rr_grant", 32'(req_ready), 32'(1) << g);
            @(negedge usr_clk);
            checkOutput("ready_outside_idle", 32'(req_ready), 32'd0);
            req_valid[g] = 1'b0;
            checkOutput("rr_cur_id", 32'(cur_id), 32'(g));
            driveChunks(g, 32'h4000_0000 + 32'(g) * 32'h100, 32'(g) * 32'h1000, 1, 32'd64);
        end

        // Table of single-requester jobs
        for (int i = 0; i < 6; i++)
            runJob(vecs[i]);

        // Engine back-pressure: cfg held stable, stray xfer_done during ISSUE ignored
        applyStimulus(1, 32'h5000_0000, 32'h300, 32'h40);
        #1;
        checkOutput("stall_ready", 32'(req_ready), 32'b0010);
        @(negedge usr_clk);
        req_valid = '0;
        for (int s = 0; s < 5; s++) begin
            checkOutput("stall_cfg_valid", 32'(cfg_valid), 32'd1);
            checkOutput("stall_cfg_src", cfg_src_sa, 32'h5000_0000);
            checkOutput("stall_cfg_dst", cfg_dst_sa, 32'h300);
            checkOutput("stall_cfg_len", cfg_len, 32'h40);
            xfer_done = (s == 2);
            @(negedge usr_clk);
        end
        xfer_done = 1'b0;
        checkOutput("stall_no_done", 32'(req_done), 32'd0);
        driveChunks(1, 32'h5000_0000, 32'h300, 1, 32'h40);

        // Reset while waiting on the first chunk of a three-chunk job
        applyStimulus(2, 32'h2000_0000, 32'h0, 32'd10000);
        #1;
        checkOutput("abort_ready", 32'(req_ready), 32'b0100);
        @(negedge usr_clk);
        req_valid = '0;
        cfg_ready = 1'b1;
        @(negedge usr_clk);
        cfg_ready = 1'b0;
        usr_reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_cfg_valid", 32'(cfg_valid), 32'd0);
        checkOutput("abort_cfg_len", cfg_len, 32'd0);
        checkOutput("abort_cfg_src", cfg_src_sa, 32'd0);
        checkOutput("abort_cur_id", 32'(cur_id), 32'd0);
        xfer_done = 1'b1;
        @(negedge usr_clk);
        xfer_done = 1'b0;
        checkOutput("abort_no_done", 32'(req_done), 32'd0);
        applyStimulus(3, 32'h6000_0000, 32'h500, 32'h80);
        applyStimulus(1, 32'h7000_0000, 32'h600, 32'h80);
        usr_reset_n = 1'b1;
        #1;
        checkOutput("abort_ptr_reset", 32'(req_ready), 32'b0010);
        @(negedge usr_clk);
        req_valid = '0;
        driveChunks(1, 32'h7000_0000, 32'h600, 1, 32'h80);
        runJob('{2, 32'h2000_0000, 32'h0, 32'd10000, 3, 32'd1808});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
